// File: rtl/hex_display_master_pkg.sv
// Shared definitions for the hex display master: FSM encoding, segment table, default spacing.
package hex_display_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_STRIDE = 16;

  // Active-low gfedcba patterns, indexed by nibble value.
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to active-low 7-segment pattern; purely combinational, no backpressure.
module hex_to_seg7
  import hex_display_master_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG7_TABLE[nibble];

endmodule

// File: rtl/hex_display_master.sv
// Avalon-MM master refreshing NUM_DIGITS 7-segment PIOs, optional read-back verify.
// First strobe one cycle after update; every transfer holds while avm_waitrequest is high.
module hex_display_master
  import hex_display_master_pkg::*;
#(
  parameter int         NUM_DIGITS = 4,
  parameter logic [7:0] BASE_ADDR  = 8'h00,
  parameter int         STRIDE     = DEFAULT_STRIDE,
  parameter bit         VERIFY     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    update,
  input  logic                    clr_err,
  output logic [7:0]              avm_address,
  output logic                    avm_write,
  output logic                    avm_read,
  output logic [6:0]              avm_writedata,
  input  logic [6:0]              avm_readdata,
  input  logic                    avm_waitrequest,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int VW = 4 * NUM_DIGITS;

  state_t          state;
  logic [2:0]      digit;
  logic [VW-1:0]   latched;
  logic [VW-1:0]   pend_val;
  logic            pending;

  logic            launch;
  logic            last_digit;
  logic            xfer_ok;
  logic            advance;
  logic            mismatch;
  logic [VW-1:0]   start_src;
  logic [2:0]      digit_nxt;
  logic [3:0]      nib_nxt;
  logic [6:0]      seg_nxt;
  logic [7:0]      addr_nxt;

  // Address and pattern for whichever digit the next write strobe will target.
  always_comb begin
    launch     = (state == ST_IDLE) || (state == ST_DONE);
    last_digit = (digit == 3'(NUM_DIGITS - 1));
    xfer_ok    = !avm_waitrequest;
    advance    = xfer_ok && (((state == ST_WRITE) && !VERIFY) || (state == ST_READ));
    mismatch   = (state == ST_READ) && xfer_ok && (avm_readdata != avm_writedata);
    start_src  = update ? value : pend_val;
    digit_nxt  = launch ? 3'd0 : digit + 3'd1;
    nib_nxt    = launch ? start_src[3:0] : 4'(latched >> {digit_nxt, 2'b00});
    addr_nxt   = BASE_ADDR + 8'(int'(digit_nxt) * STRIDE);
  end

  hex_to_seg7 u_seg (
    .nibble (nib_nxt),
    .seg    (seg_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      digit         <= 3'd0;
      latched       <= '0;
      pend_val      <= '0;
      pending       <= 1'b0;
      avm_address   <= 8'h00;
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      avm_writedata <= 7'h00;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      err  <= mismatch | (err & ~clr_err);
      done <= 1'b0;

      // Requests arriving mid-refresh collapse into one, keeping the newest value.
      if (update && ((state == ST_WRITE) || (state == ST_READ))) begin
        pending  <= 1'b1;
        pend_val <= value;
      end

      if (launch && (update || pending)) begin
        latched       <= start_src;
        pending       <= 1'b0;
        digit         <= 3'd0;
        state         <= ST_WRITE;
        avm_write     <= 1'b1;
        avm_address   <= addr_nxt;
        avm_writedata <= seg_nxt;
        busy          <= 1'b1;
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end

      if ((state == ST_WRITE) && xfer_ok && VERIFY) begin
        avm_write <= 1'b0;
        avm_read  <= 1'b1;
        state     <= ST_READ;
      end

      if (advance) begin
        avm_read <= 1'b0;
        if (last_digit) begin
          avm_write <= 1'b0;
          state     <= ST_DONE;
          done      <= 1'b1;
        end else begin
          digit         <= digit_nxt;
          state         <= ST_WRITE;
          avm_write     <= 1'b1;
          avm_address   <= addr_nxt;
          avm_writedata <= seg_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_display_master.sv
// Randomised bench for hex_display_master: slave model, transaction scoreboard, timing checks.
module tb_hex_display_master;

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [6:0] dat;
  } txn_t;

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] a_value = '0;
  logic        a_update = 1'b0, a_clr_err = 1'b0;
  logic [7:0]  a_avm_address;
  logic        a_avm_write, a_avm_read;
  logic [6:0]  a_avm_writedata;
  logic [6:0]  a_avm_readdata = '0;
  logic        a_avm_waitrequest = 1'b0;
  logic        a_busy, a_done, a_err;

  logic [31:0] b_value = '0;
  logic        b_update = 1'b0, b_clr_err = 1'b0;
  logic [7:0]  b_avm_address;
  logic        b_avm_write, b_avm_read;
  logic [6:0]  b_avm_writedata;
  logic [6:0]  b_avm_readdata = '0;
  logic        b_avm_waitrequest = 1'b0;
  logic        b_busy, b_done, b_err;

  hex_display_master #(.NUM_DIGITS(4), .BASE_ADDR(8'h00), .STRIDE(16), .VERIFY(1'b1)) dut (
    .clk(clk), .reset(reset), .value(a_value), .update(a_update), .clr_err(a_clr_err),
    .avm_address(a_avm_address), .avm_write(a_avm_write), .avm_read(a_avm_read),
    .avm_writedata(a_avm_writedata), .avm_readdata(a_avm_readdata),
    .avm_waitrequest(a_avm_waitrequest), .busy(a_busy), .done(a_done), .err(a_err)
  );

  hex_display_master #(.NUM_DIGITS(8), .BASE_ADDR(8'hF0), .STRIDE(16), .VERIFY(1'b0)) dut8 (
    .clk(clk), .reset(reset), .value(b_value), .update(b_update), .clr_err(b_clr_err),
    .avm_address(b_avm_address), .avm_write(b_avm_write), .avm_read(b_avm_read),
    .avm_writedata(b_avm_writedata), .avm_readdata(b_avm_readdata),
    .avm_waitrequest(b_avm_waitrequest), .busy(b_busy), .done(b_done), .err(b_err)
  );

  int nvec = 0, nerr = 0, cyc = 0;
  int a_t0 = 0, b_t0 = 0;
  txn_t a_log[$], a_exp[$], b_log[$], b_exp[$];
  int a_log_cyc[$], a_done_cyc[$], b_log_cyc[$], b_done_cyc[$];
  logic [6:0] a_mem [256];
  int wait_mode = 0, stall_left = 0;
  logic [7:0] stall_addr = '0, corrupt_addr = '0;
  logic corrupt_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [16:0] prev_bus = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // One clock: sample outputs at the falling edge, drive slave responses, log completed transfers.
  task automatic step();
    logic w, strobe;
    txn_t t;
    @(negedge clk);
    cyc++;
    if (a_done) a_done_cyc.push_back(cyc);
    if (b_done) b_done_cyc.push_back(cyc);
    if (prev_stall && !reset)
      check("stall_hold", {a_avm_write, a_avm_read, a_avm_address, a_avm_writedata}, prev_bus);
    strobe = a_avm_write | a_avm_read;
    if (strobe) check("one_strobe", a_avm_write & a_avm_read, 0);
    w = 1'b0;
    case (wait_mode)
      1: if (a_avm_write && a_avm_address == stall_addr && stall_left > 0) begin
           w = 1'b1;
           stall_left--;
         end
      2: w = ($urandom_range(0, 2) == 0);
      default: w = 1'b0;
    endcase
    a_avm_waitrequest = w;
    a_avm_readdata = (corrupt_en && a_avm_address == corrupt_addr) ? 7'h7F : a_mem[a_avm_address];
    if (strobe && !w && !reset) begin
      t.rd = a_avm_read;
      t.addr = a_avm_address;
      t.dat = a_avm_write ? a_avm_writedata : 7'h00;
      a_log.push_back(t);
      a_log_cyc.push_back(cyc);
      if (a_avm_write) a_mem[a_avm_address] = a_avm_writedata;
    end
    prev_stall = strobe && w;
    prev_bus = {a_avm_write, a_avm_read, a_avm_address, a_avm_writedata};
    if ((b_avm_write || b_avm_read) && !reset) begin
      t.rd = b_avm_read;
      t.addr = b_avm_address;
      t.dat = b_avm_write ? b_avm_writedata : 7'h00;
      b_log.push_back(t);
      b_log_cyc.push_back(cyc);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reference: a refresh of v writes each digit's pattern in order, each verified by a read.
  task automatic exp_a(input logic [15:0] v);
    txn_t t;
    for (int i = 0; i < 4; i++) begin
      t.rd = 1'b0; t.addr = 8'(i * 16); t.dat = SEG_REF[v[4*i +: 4]];
      a_exp.push_back(t);
      t.rd = 1'b1; t.dat = 7'h00;
      a_exp.push_back(t);
    end
  endtask

  task automatic exp_b(input logic [31:0] v);
    txn_t t;
    for (int i = 0; i < 8; i++) begin
      t.rd = 1'b0; t.addr = 8'((240 + i * 16) % 256); t.dat = SEG_REF[v[4*i +: 4]];
      b_exp.push_back(t);
    end
  endtask

  task automatic cmp_a(input string tag);
    check({tag, "_count"}, a_log.size(), a_exp.size());
    for (int i = 0; i < a_exp.size() && i < a_log.size(); i++)
      check($sformatf("%s_txn%0d", tag, i), a_log[i], a_exp[i]);
  endtask

  task automatic clear_a();
    a_log.delete(); a_exp.delete(); a_log_cyc.delete(); a_done_cyc.delete();
  endtask

  task automatic start_a(input logic [15:0] v);
    a_value = v; a_update = 1'b1; a_t0 = cyc;
    step();
    a_update = 1'b0;
  endtask

  task automatic pulse_a(input logic [15:0] v);
    a_value = v; a_update = 1'b1;
    step();
    a_update = 1'b0;
  endtask

  task automatic wait_a(input int n);
    int k = 0;
    while (a_done_cyc.size() < n && k < 300) begin step(); k++; end
    if (a_done_cyc.size() < n) check("a_done_timeout", a_done_cyc.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [15:0] v, v2;
    int nd;
    for (int i = 0; i < 256; i++) a_mem[i] = 7'h00;

    steps(3);
    check("rst_a", {a_avm_write, a_avm_read, a_avm_address, a_avm_writedata, a_busy, a_done, a_err}, 0);
    check("rst_b", {b_avm_write, b_avm_read, b_avm_address, b_avm_writedata, b_busy, b_done, b_err}, 0);
    reset = 1'b0;
    steps(2);

    // Zero-wait refresh of 1234 with verify.
    clear_a(); exp_a(16'h1234);
    start_a(16'h1234);
    check("t1_busy", a_busy, 1);
    wait_a(1); steps(3);
    cmp_a("t1");
    if (a_log_cyc.size() > 0) check("t1_first_wr", a_log_cyc[0] - a_t0, 1);
    if (a_done_cyc.size() > 0) check("t1_done_cyc", a_done_cyc[0] - a_t0, 9);
    check("t1_ndone", a_done_cyc.size(), 1);
    check("t1_err", a_err, 0);
    check("t1_idle_busy", a_busy, 0);

    // Three stall cycles on the digit 2 write.
    clear_a(); exp_a(16'h1234);
    wait_mode = 1; stall_addr = 8'h20; stall_left = 3;
    start_a(16'h1234);
    wait_a(1); steps(3);
    cmp_a("t2");
    if (a_done_cyc.size() > 0) check("t2_done_cyc", a_done_cyc[0] - a_t0, 12);
    wait_mode = 0;

    // Corrupted read-back of digit 1 sets sticky err.
    clear_a(); exp_a(16'h5A3C);
    corrupt_en = 1'b1; corrupt_addr = 8'h10;
    start_a(16'h5A3C);
    steps(3);
    check("t3_err_before", a_err, 0);
    step();
    check("t3_err_after", a_err, 1);
    wait_a(1); steps(4);
    cmp_a("t3");
    check("t3_err_sticky", a_err, 1);
    a_clr_err = 1'b1; step(); a_clr_err = 0;
    check("t3_err_clr", a_err, 0);

    // clr_err held through a mismatch: the mismatch wins that cycle.
    clear_a();
    a_clr_err = 1'b1;
    start_a(16'h0F0F);
    steps(4);
    check("t3_mismatch_wins", a_err, 1);
    step();
    check("t3_clr_next", a_err, 0);
    a_clr_err = 1'b0;
    wait_a(1); steps(2);
    corrupt_en = 1'b0;

    // Updates while busy merge; the newest value is shown right after done.
    clear_a(); exp_a(16'hABCD); exp_a(16'hEF00);
    start_a(16'hABCD);
    step(); pulse_a(16'h1111); pulse_a(16'hEF00);
    wait_a(2); steps(3);
    cmp_a("t4");
    check("t4_ndone", a_done_cyc.size(), 2);
    if (a_done_cyc.size() > 1) check("t4_done_gap", a_done_cyc[1] - a_done_cyc[0], 9);
    if (a_log_cyc.size() > 8 && a_done_cyc.size() > 0)
      check("t4_restart", a_log_cyc[8] - a_done_cyc[0], 1);

    // Reset in the middle of a stalled write abandons it.
    clear_a();
    wait_mode = 1; stall_addr = 8'h00; stall_left = 100;
    start_a(16'h4321);
    step();
    check("t5_stalled_wr", a_avm_write, 1);
    reset = 1'b1; step();
    check("t5_reset", {a_avm_write, a_avm_read, a_avm_address, a_avm_writedata, a_busy, a_done}, 0);
    reset = 1'b0; wait_mode = 0; stall_left = 0;
    steps(3);
    check("t5_no_resume", {a_avm_write, a_avm_read, a_busy}, 0);
    clear_a(); exp_a(16'h4321);
    start_a(16'h4321);
    wait_a(1); steps(2);
    cmp_a("t5");
    if (a_log_cyc.size() > 0) check("t5_first_wr", a_log_cyc[0] - a_t0, 1);

    // Eight digits, no verify, address wrap from F0.
    b_exp.delete(); b_log.delete(); b_log_cyc.delete(); b_done_cyc.delete();
    exp_b(32'h89AB_CDEF);
    b_value = 32'h89AB_CDEF; b_update = 1'b1; b_t0 = cyc;
    step();
    b_update = 1'b0;
    for (int k = 0; k < 50 && b_done_cyc.size() == 0; k++) step();
    steps(2);
    check("t6_count", b_log.size(), b_exp.size());
    for (int i = 0; i < b_exp.size() && i < b_log.size(); i++)
      check($sformatf("t6_txn%0d", i), b_log[i], b_exp[i]);
    check("t6_ndone", b_done_cyc.size(), 1);
    if (b_done_cyc.size() > 0) check("t6_done_cyc", b_done_cyc[0] - b_t0, 9);
    if (b_log_cyc.size() > 0) check("t6_first_wr", b_log_cyc[0] - b_t0, 1);

    // Random values, random waitrequest, optional merged mid-refresh updates.
    wait_mode = 2;
    for (int it = 0; it < 10; it++) begin
      clear_a();
      v = 16'($urandom);
      exp_a(v);
      nd = 1;
      start_a(v);
      if ($urandom_range(0, 1) == 1) begin
        step();
        v2 = 16'($urandom);
        pulse_a(v2);
        if ($urandom_range(0, 1) == 1) begin
          v2 = 16'($urandom);
          pulse_a(v2);
        end
        exp_a(v2);
        nd = 2;
      end
      wait_a(nd); steps(3);
      cmp_a($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_ndone", it), a_done_cyc.size(), nd);
      check($sformatf("rnd%0d_err", it), a_err, 0);
    end
    wait_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hex_display_master.md
HEX_DISPLAY_MASTER -- requirements
Module: hex_display_master

Interface
REQ-001 NUM_DIGITS, 4, number of 7-segment PIO slaves driven (1..8).
REQ-002 BASE_ADDR, 8'h00, byte address of digit 0 PIO.
REQ-003 STRIDE, 16, byte spacing between consecutive digit PIOs (4 words each).
REQ-004 VERIFY, 1, when 1 each write is followed by a read-back compare.
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 value  input  4*NUM_DIGITS  hex value to display, digit i = value[4i+3:4i].
REQ-008 update  input  1  single-cycle request to refresh all digits.
REQ-009 clr_err  input  1  clears sticky err.
REQ-010 avm_address  output  8  Avalon-MM byte address.
REQ-011 avm_write  output  1  Avalon-MM write strobe.
REQ-012 avm_read  output  1  Avalon-MM read strobe.
REQ-013 avm_writedata  output  7  segment pattern, active-low, bit0=seg a.
REQ-014 avm_readdata  input  7  read-back data, valid in the cycle read is accepted (read latency 0).
REQ-015 avm_waitrequest  input  1  slave stall; transfer completes in the cycle strobe=1 and waitrequest=0.
REQ-016 busy  output  1  high from the cycle after update is accepted until done.
REQ-017 done  output  1  one-cycle pulse when all digits are written (and verified).
REQ-018 err  output  1  sticky read-back mismatch flag.

Function
REQ-019 FSM states SHALL be IDLE, WRITE, READ, DONE.
REQ-020 IDLE: on update=1, latch value into an internal register, clear digit index to 0, go to WRITE next cycle.
REQ-021 WRITE: avm_write=1, avm_address=BASE_ADDR+digit*STRIDE (mod 256), avm_writedata=seg7(latched nibble); all held stable while avm_waitrequest=1.
REQ-022 WRITE completion: go to READ if VERIFY=1, else advance digit.
REQ-023 READ: avm_read=1 at the same address; on completion, set err if avm_readdata != expected pattern.
REQ-024 Advance: if digit==NUM_DIGITS-1 go to DONE, else digit+1 and return to WRITE.
REQ-025 DONE: done=1 for exactly one cycle; go to WRITE with new latched value if pending set, else IDLE.
REQ-026 avm_write and avm_read SHALL never be high in the same cycle.
REQ-027 update while busy SHALL set a single pending flag (multiple requests merge), capturing the most recent value; the pending flag clears when a refresh is started from it.
REQ-028 Zero-wait latency: update at cycle 0 -> first write strobe at cycle 1 -> done at cycle 1+NUM_DIGITS*(1+VERIFY).
REQ-029 Encoding (active-low, gfedcba): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,B=03,C=46,D=21,E=06,F=0E (hex).
REQ-030 clr_err clears err; when clr_err coincides with a new mismatch, err SHALL be set (mismatch wins).

Reset
REQ-031 reset SHALL force state IDLE, digit 0, pending 0, latched value 0, err 0, and drive avm_write=0, avm_read=0, avm_address=0, avm_writedata=0, busy=0, done=0 from the next edge.
REQ-032 reset asserted mid-transfer SHALL abandon the transfer regardless of avm_waitrequest; no resumption after release.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding, the 16-entry seg7 table and the default STRIDE constant.
REQ-034 The nibble-to-segment encoder SHALL be a combinational sub-module hex_to_seg7 (4-bit in, 7-bit out).

Verification
REQ-035 value=16'h1234, update, no waitrequest, VERIFY=1 -> writes 19@00,30@10,24@20,79@30 each followed by a read; done at cycle 9; err=0.
REQ-036 avm_waitrequest high 3 cycles on digit 2 write -> address/data stable throughout, single completed write, done delayed by 3 cycles.
REQ-037 Slave returns 7F on digit 1 read -> err=1 after that read, remaining digits still written, err stays set until clr_err.
REQ-038 update with 16'hABCD then 16'hEF00 while busy -> second refresh starts immediately after done, writes 40,40,0E,06; done pulses twice.
REQ-039 reset asserted during WRITE with waitrequest=1 -> avm_write=0, busy=0 at next edge; later update restarts at digit 0.
REQ-040 VERIFY=0, NUM_DIGITS=8, BASE_ADDR=8'hF0 -> no reads, addresses wrap F0,00,10..60, done at cycle 9.
